// File: rtl/simd_regfile_pkg.sv
// Shared constants and types for the 4-lane SIMD FP register file.
package simd_regfile_pkg;

    localparam int width_p       = 33;
    localparam int els_p         = 32;
    localparam int lanes_p       = 4;
    localparam int num_rs_p      = 3;
    localparam int addr_width_lp = $clog2(els_p);

    localparam int RS1 = 0;
    localparam int RS2 = 1;
    localparam int RS3 = 2;

    typedef logic [width_p-1:0] fp_word_t;
    typedef logic [addr_width_lp-1:0] reg_addr_t;

endpackage

// File: rtl/simd_regfile_bank.sv
// One lane of the FP register file: single write port, N synchronous
// read ports with per-port enable and output hold.
module simd_regfile_bank
    import simd_regfile_pkg::*;
#(
    parameter int ports = num_rs_p
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  w_v_i,
    input  reg_addr_t             w_addr_i,
    input  fp_word_t              w_data_i,
    input  logic      [ports-1:0] r_v_i,
    input  reg_addr_t [ports-1:0] r_addr_i,
    output fp_word_t  [ports-1:0] r_data_o
);

    fp_word_t mem [els_p];

    // Reads sample mem before the write lands, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int e = 0; e < els_p; e++) begin
                mem[e] <= '0;
            end
            r_data_o <= '0;
        end else begin
            if (w_v_i) begin
                mem[w_addr_i] <= w_data_i;
            end
            for (int p = 0; p < ports; p++) begin
                if (r_v_i[p]) begin
                    r_data_o[p] <= mem[r_addr_i[p]];
                end
            end
        end
    end

endmodule

// File: rtl/simd_regfile.sv
// 4-lane SIMD FP register file: lane 0 serves the scalar rs1/rs2/rs3
// ports, lanes 1..3 supply the SIMD view of the rs2 register.
module simd_regfile
    import simd_regfile_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic      [lanes_p-1:0]  w_v_i,
    input  reg_addr_t                w_addr_i,
    input  fp_word_t  [lanes_p-1:0]  w_data_i,
    input  logic      [num_rs_p-1:0] r_v_i,
    input  reg_addr_t [num_rs_p-1:0] r_addr_i,
    output fp_word_t  [num_rs_p-1:0] r_data_o,
    output fp_word_t  [lanes_p-2:0]  rs2_simd_data_o
);

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        if (k == 0) begin : g_scalar
            simd_regfile_bank #(
                .ports(num_rs_p)
            ) u_bank (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .w_v_i   (w_v_i[k]),
                .w_addr_i(w_addr_i),
                .w_data_i(w_data_i[k]),
                .r_v_i   (r_v_i),
                .r_addr_i(r_addr_i),
                .r_data_o(r_data_o)
            );
        end else begin : g_simd
            // SIMD lanes only ever answer the rs2 port.
            simd_regfile_bank #(
                .ports(1)
            ) u_bank (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .w_v_i   (w_v_i[k]),
                .w_addr_i(w_addr_i),
                .w_data_i(w_data_i[k]),
                .r_v_i   (r_v_i[RS2]),
                .r_addr_i(r_addr_i[RS2]),
                .r_data_o(rs2_simd_data_o[k-1])
            );
        end
    end

endmodule

// File: tb/tb_simd_regfile.sv
// Directed + random bench for simd_regfile with a queued expected-output
// scoreboard fed by a behavioural model of the register file.
module tb_simd_regfile;
    import simd_regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic [lanes_p-1:0] w_v;
    logic [4:0] w_addr;
    logic [lanes_p-1:0][32:0] w_data;
    logic [2:0] r_v;
    logic [2:0][4:0] r_addr;
    logic [2:0][32:0] r_data;
    logic [2:0][32:0] simd_data;

    always #5 clk = ~clk;

    simd_regfile dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .w_v_i          (w_v),
        .w_addr_i       (w_addr),
        .w_data_i       (w_data),
        .r_v_i          (r_v),
        .r_addr_i       (r_addr),
        .r_data_o       (r_data),
        .rs2_simd_data_o(simd_data)
    );

    typedef struct {
        logic [2:0][32:0] r;
        logic [2:0][32:0] s;
    } exp_t;

    exp_t sb[$];
    logic [32:0] mdl [lanes_p][els_p];
    logic [2:0][32:0] mr;
    logic [2:0][32:0] ms;
    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string tag, input int idx,
                       input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    // Drive one cycle; the model predicts outputs, pushes them, then checks.
    task automatic step(input logic rst, input logic [3:0] wv,
                        input logic [4:0] wa, input logic [3:0][32:0] wd,
                        input logic [2:0] rv, input logic [2:0][4:0] ra);
        exp_t e;
        reset = rst; w_v = wv; w_addr = wa; w_data = wd;
        r_v = rv; r_addr = ra;
        if (rst) begin
            mr = '0;
            ms = '0;
            for (int l = 0; l < lanes_p; l++)
                for (int a = 0; a < els_p; a++) mdl[l][a] = '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (rv[i]) mr[i] = mdl[0][ra[i]];
            if (rv[1])
                for (int j = 0; j < 3; j++) ms[j] = mdl[j+1][ra[1]];
            for (int l = 0; l < lanes_p; l++)
                if (wv[l]) mdl[l][wa] = wd[l];
        end
        e.r = mr;
        e.s = ms;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) cmp("r_data", i, r_data[i], e.r[i]);
        for (int j = 0; j < 3; j++) cmp("simd", j, simd_data[j], e.s[j]);
    endtask

    function automatic logic [3:0][32:0] fill(input logic [32:0] v);
        logic [3:0][32:0] d;
        for (int l = 0; l < 4; l++) d[l] = v;
        return d;
    endfunction

    function automatic logic [2:0][4:0] addr3(input logic [4:0] a0,
                                              input logic [4:0] a1,
                                              input logic [4:0] a2);
        logic [2:0][4:0] a;
        a[0] = a0; a[1] = a1; a[2] = a2;
        return a;
    endfunction

    initial begin
        logic [3:0][32:0] d;
        logic [3:0][32:0] rd;
        reset = 1'b1; w_v = '0; w_addr = '0; w_data = '0;
        r_v = '0; r_addr = '0;
        for (int l = 0; l < lanes_p; l++)
            for (int a = 0; a < els_p; a++) mdl[l][a] = '0;
        mr = '0; ms = '0;
        @(negedge clk);

        // 1: reset then read all ports
        step(1, 0, 0, '0, 0, '0);
        step(1, 0, 0, '0, 0, '0);
        step(0, 0, 0, '0, 3'b111, addr3(0, 1, 2));
        for (int i = 0; i < 3; i++) cmp("t1_r", i, r_data[i], 33'd0);

        // 2: lane-0 only write
        d[0] = 33'd2; d[1] = 33'd3; d[2] = 33'd4; d[3] = 33'd5;
        step(0, 4'b0001, 0, d, 0, '0);
        step(0, 0, 0, '0, 3'b010, addr3(0, 0, 0));
        cmp("t2_rs2", 1, r_data[1], 33'd2);
        cmp("t2_simd", 2, simd_data[2], 33'd0);

        // 3: all-lane write, mixed reads
        step(0, 4'b1111, 0, fill(33'd7), 0, '0);
        step(0, 0, 0, '0, 3'b111, addr3(0, 0, 2));
        cmp("t3_rs1", 0, r_data[0], 33'd7);
        cmp("t3_rs3", 2, r_data[2], 33'd0);
        cmp("t3_simd", 0, simd_data[0], 33'd7);

        // 4: lane-1 write at addr 30, reads at 30/31
        step(0, 4'b0010, 30, fill(33'd7), 0, '0);
        step(0, 0, 0, '0, 3'b110, addr3(0, 30, 31));
        cmp("t4_rs2", 1, r_data[1], 33'd0);
        cmp("t4_simd", 0, simd_data[0], 33'd7);
        cmp("t4_simd", 2, simd_data[2], 33'd0);

        // 5: read-before-write on the same edge
        step(0, 4'b0001, 5, fill(33'h1_2345_6789), 3'b001, addr3(5, 0, 0));
        cmp("t5_old", 0, r_data[0], 33'd0);
        step(0, 0, 0, '0, 3'b001, addr3(5, 0, 0));
        cmp("t5_new", 0, r_data[0], 33'h1_2345_6789);

        // Random traffic, including address 0 and 31
        for (int n = 0; n < 60; n++) begin
            for (int l = 0; l < 4; l++)
                rd[l] = {$urandom_range(1, 0), $urandom()};
            step(0, 4'($urandom()), 5'($urandom()), rd, 3'($urandom()),
                 addr3(5'($urandom()), 5'($urandom()), 5'($urandom())));
        end

        // 6: valid read, then hold while writes continue
        step(0, 0, 0, '0, 3'b111, addr3(5, 0, 30));
        for (int n = 0; n < 4; n++)
            step(0, 4'b1111, 5'(n), fill(33'h0_dead_0000 + 33'(n)), 0,
                 addr3(5'(n), 5'(n), 5'(n)));
        step(0, 4'b1111, 7, fill(33'h1_5555_5555), 3'b111, addr3(7, 7, 7));
        step(1, 4'b1111, 9, fill(33'h1_aaaa_aaaa), 3'b111, addr3(9, 9, 9));
        for (int i = 0; i < 3; i++) cmp("t6_rst", i, r_data[i], 33'd0);
        for (int a = 0; a < els_p; a++)
            step(0, 0, 0, '0, 3'b111, addr3(5'(a), 5'(a), 5'(a)));
        cmp("t6_end", 0, simd_data[0], 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
